// File: rtl/vram_arbiter_pkg.sv
// Shared video package: arbiter state encoding and default VRAM geometry.
//   DEF_ADDR_W   - VRAM word-address width (4096 tile entries)
//   DEF_DATA_W   - VRAM data width
//   DEF_MAX_WAIT - denied CPU cycles in active video before a forced slot
//   arb_state_e  - arbiter priority state
package vram_arbiter_pkg;

  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    DISP_PRI  = 2'd0,  // active video: display fetches win
    CPU_PRI   = 2'd1,  // blanking: CPU accesses win
    FORCE_CPU = 2'd2   // one-cycle anti-starvation slot for the CPU
  } arb_state_e;

endpackage

// File: rtl/limit_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset (count -> 0)
//   clr   - synchronous clear, dominates inc
//   inc   - count up by one, holding at LIMIT
//   count - current count
module limit_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_r;

  // Counter register: clear wins over increment, increment saturates at LIMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != LIMIT_V)) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the display fetch path and the CPU.
// Active video favours the display, blanking favours the CPU, and a CPU
// denied MAX_WAIT consecutive cycles in active video gets a forced slot.
// Ports:
//   clk, reset                      - system clock, synchronous active-high reset
//   blank                           - 1 outside the visible area
//   disp_req/disp_addr              - display read request (held until disp_gnt)
//   disp_gnt/disp_valid/disp_rdata  - display grant, read-data strobe and data
//   cpu_req/cpu_we/cpu_addr/cpu_wdata - CPU request (held until cpu_gnt)
//   cpu_gnt/cpu_rvalid/cpu_rdata    - CPU grant, read-data strobe and data
//   mem_addr/mem_we/mem_wdata       - VRAM command (same cycle as the grant)
//   mem_rdata                       - VRAM read data, one cycle after command
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  // Count value at which one more denial makes the counter reach MAX_WAIT.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic              disp_gnt_s;
  logic              cpu_gnt_s;
  logic              wait_inc_s;
  logic              wait_clr_s;
  logic              wait_hit_s;
  logic [CNT_W-1:0]  wait_cnt_s;
  logic              disp_valid_r;
  logic              cpu_rvalid_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] wdata_hold_r;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic              mem_we_s;

  // Wait counter tracks consecutive denied CPU cycles in active video.
  assign wait_inc_s = cpu_req & ~cpu_gnt_s & ~blank;
  assign wait_clr_s = cpu_gnt_s | ~cpu_req | blank;
  // The counter reaches MAX_WAIT at this edge, so the forced slot is the
  // very next cycle: a CPU denied MAX_WAIT times is granted on try MAX_WAIT+1.
  assign wait_hit_s = wait_inc_s && (wait_cnt_s == WAIT_LAST);

  limit_counter #(
    .WIDTH (CNT_W),
    .LIMIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr_s),
    .inc   (wait_inc_s),
    .count (wait_cnt_s)
  );

  // State register: reset lands in CPU priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= CPU_PRI;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: follow blank, except a starved CPU diverts DISP_PRI to FORCE_CPU
  always_comb begin
    state_nxt_s = blank ? CPU_PRI : DISP_PRI;
    case (state_r)
      DISP_PRI: begin
        if (wait_hit_s) begin
          state_nxt_s = FORCE_CPU;
        end else begin
          state_nxt_s = blank ? CPU_PRI : DISP_PRI;
        end
      end
      CPU_PRI:   state_nxt_s = blank ? CPU_PRI : DISP_PRI;
      FORCE_CPU: state_nxt_s = blank ? CPU_PRI : DISP_PRI;
      default:   state_nxt_s = CPU_PRI;
    endcase
  end

  // Grant decode from the registered state; FORCE_CPU grants like CPU_PRI
  // because it only differs in how it was entered and that it lasts one cycle.
  always_comb begin
    disp_gnt_s = 1'b0;
    cpu_gnt_s  = 1'b0;
    case (state_r)
      DISP_PRI: begin
        disp_gnt_s = disp_req;
        cpu_gnt_s  = cpu_req & ~disp_req;
      end
      CPU_PRI, FORCE_CPU: begin
        cpu_gnt_s  = cpu_req;
        disp_gnt_s = disp_req & ~cpu_req;
      end
      default: begin
        disp_gnt_s = 1'b0;
        cpu_gnt_s  = 1'b0;
      end
    endcase
  end

  // Read strobes and last-issued command; reset drops any read in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_valid_r <= 1'b0;
      cpu_rvalid_r <= 1'b0;
      addr_hold_r  <= {ADDR_W{1'b0}};
      wdata_hold_r <= {DATA_W{1'b0}};
    end else begin
      disp_valid_r <= disp_gnt_s;
      cpu_rvalid_r <= cpu_gnt_s & ~cpu_we;
      if (cpu_gnt_s) begin
        addr_hold_r  <= cpu_addr;
        wdata_hold_r <= cpu_wdata;
      end else if (disp_gnt_s) begin
        addr_hold_r  <= disp_addr;
        wdata_hold_r <= wdata_hold_r;
      end else begin
        addr_hold_r  <= addr_hold_r;
        wdata_hold_r <= wdata_hold_r;
      end
    end
  end

  // VRAM command mux: granted port's command this cycle, otherwise hold
  always_comb begin
    mem_addr_s  = addr_hold_r;
    mem_wdata_s = wdata_hold_r;
    mem_we_s    = 1'b0;
    if (reset) begin
      mem_addr_s  = {ADDR_W{1'b0}};
      mem_wdata_s = {DATA_W{1'b0}};
      mem_we_s    = 1'b0;
    end else if (cpu_gnt_s) begin
      mem_addr_s  = cpu_addr;
      mem_wdata_s = cpu_wdata;
      mem_we_s    = cpu_we;
    end else if (disp_gnt_s) begin
      mem_addr_s  = disp_addr;
      mem_wdata_s = wdata_hold_r;
      mem_we_s    = 1'b0;
    end else begin
      mem_addr_s  = addr_hold_r;
      mem_wdata_s = wdata_hold_r;
      mem_we_s    = 1'b0;
    end
  end

  // Everything is forced low while reset is high, including the registered
  // strobes, so a read granted just before reset never surfaces.
  assign disp_gnt   = disp_gnt_s & ~reset;
  assign cpu_gnt    = cpu_gnt_s & ~reset;
  assign disp_valid = disp_valid_r & ~reset;
  assign cpu_rvalid = cpu_rvalid_r & ~reset;
  assign disp_rdata = reset ? {DATA_W{1'b0}} : mem_rdata;
  assign cpu_rdata  = reset ? {DATA_W{1'b0}} : mem_rdata;
  assign mem_addr   = mem_addr_s;
  assign mem_wdata  = mem_wdata_s;
  assign mem_we     = mem_we_s;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  import vram_arbiter_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          blank;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_valid;
  logic [DW-1:0] disp_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .blank(blank),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Power-up VRAM contents: address low byte xor 0x5A
  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // VRAM model: synchronous, one-cycle read latency
  bit [7:0] vram [0:4095];
  bit       vwr  [0:4095];
  always @(posedge clk) begin
    if (mem_we) begin
      vram[mem_addr] <= mem_wdata;
      vwr[mem_addr]  <= 1'b1;
    end
    mem_rdata <= vwr[mem_addr] ? vram[mem_addr] : pat(mem_addr);
  end

  // Reference contents as seen by the bench's own stimulus
  bit [7:0] ref_mem [0:4095];
  bit       ref_wr  [0:4095];
  function automatic logic [7:0] rd_exp(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : pat(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int   cwait, dwait, max_c, max_d, both_cnt, rd_err;
  logic d_g, c_g, exp_dv, exp_cv;
  logic [7:0] exp_dd, exp_cd;

  initial begin
    reset = 1'b1; blank = 1'b0;
    disp_req = 1'b0; disp_addr = 12'h000;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;

    // Reset: requests present but everything held at zero
    @(negedge clk);
    disp_req = 1'b1; cpu_req = 1'b1; disp_addr = 12'h123; cpu_addr = 12'h456;
    #1;
    chk("rst_disp_gnt", disp_gnt, 1'b0);
    chk("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 12'h000);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_valids", {disp_valid, cpu_rvalid}, 2'b00);
    chk("rst_rdata", {disp_rdata, cpu_rdata}, 16'h0000);
    chk("rst_state", 32'(dut.state_r), 32'(CPU_PRI));
    chk("rst_wait_cnt", 32'(dut.wait_cnt_s), 32'd0);

    // Idle active-video cycle moves CPU_PRI -> DISP_PRI
    @(negedge clk);
    reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;
    #1;
    chk("post_rst_valid", {disp_valid, cpu_rvalid}, 2'b00);

    // S1: active video, both request -> display first
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 12'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
    #1;
    chk("s1_disp_gnt", disp_gnt, 1'b1);
    chk("s1_cpu_gnt", cpu_gnt, 1'b0);
    chk("s1_mem_addr", mem_addr, 12'h010);
    chk("s1_mem_we", mem_we, 1'b0);
    @(negedge clk);
    disp_req = 1'b0;
    #1;
    chk("s1_disp_valid", disp_valid, 1'b1);
    chk("s1_disp_rdata", disp_rdata, 8'h4A);
    chk("s1_cpu_gnt2", cpu_gnt, 1'b1);
    chk("s1_mem_addr2", mem_addr, 12'h020);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("s1_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("s1_cpu_rdata", cpu_rdata, 8'h7A);
    chk("s1_disp_valid_pulse", disp_valid, 1'b0);
    chk("s1_hold_addr", mem_addr, 12'h020);
    chk("s1_hold_we", mem_we, 1'b0);

    // S2: blanking, both request -> CPU first, display next
    @(negedge clk);
    blank = 1'b1;
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 12'h030;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
    #1;
    chk("s2_cpu_gnt", cpu_gnt, 1'b1);
    chk("s2_disp_gnt", disp_gnt, 1'b0);
    chk("s2_mem_addr", mem_addr, 12'h040);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("s2_disp_gnt2", disp_gnt, 1'b1);
    chk("s2_mem_addr2", mem_addr, 12'h030);
    chk("s2_cpu_rvalid", cpu_rvalid, 1'b1);
    chk("s2_cpu_rdata", cpu_rdata, 8'h1A);
    @(negedge clk);
    disp_req = 1'b0;
    #1;
    chk("s2_disp_valid", disp_valid, 1'b1);
    chk("s2_disp_rdata", disp_rdata, 8'h6A);

    // S3: CPU write then read-back during blanking
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h3FF; cpu_wdata = 8'hA5;
    ref_mem[12'h3FF] = 8'hA5; ref_wr[12'h3FF] = 1'b1;
    #1;
    chk("s3_wr_gnt", cpu_gnt, 1'b1);
    chk("s3_wr_we", mem_we, 1'b1);
    chk("s3_wr_addr", mem_addr, 12'h3FF);
    chk("s3_wr_data", mem_wdata, 8'hA5);
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    chk("s3_rd_gnt", cpu_gnt, 1'b1);
    chk("s3_rd_we", mem_we, 1'b0);
    chk("s3_no_wr_rvalid", cpu_rvalid, 1'b0);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("s3_rvalid", cpu_rvalid, 1'b1);
    chk("s3_rdata", cpu_rdata, 8'hA5);
    chk("s3_hold_addr", mem_addr, 12'h3FF);

    // Blank rises in the same cycle as both requests: registered DISP_PRI decides
    @(negedge clk);
    blank = 1'b0;
    @(negedge clk);
    blank = 1'b1;
    disp_req = 1'b1; disp_addr = 12'h011;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h012;
    #1;
    chk("edge_disp_gnt", disp_gnt, 1'b1);
    chk("edge_cpu_gnt", cpu_gnt, 1'b0);
    @(negedge clk);
    disp_req = 1'b0;
    #1;
    chk("edge_cpu_gnt2", cpu_gnt, 1'b1);
    @(negedge clk);
    cpu_req = 1'b0; blank = 1'b0;

    // S4: display hogs active video, CPU forced in on attempt 16
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        disp_req = 1'b1; disp_addr = 12'h100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h055;
      end
      if (k == 17) cpu_req = 1'b0;
      #1;
      chk($sformatf("s4_cpu_gnt_%0d", k), cpu_gnt, (k == 16) ? 1'b1 : 1'b0);
      chk($sformatf("s4_disp_gnt_%0d", k), disp_gnt, (k == 16) ? 1'b0 : 1'b1);
      if (k == 17) begin
        chk("s4_cpu_rvalid", cpu_rvalid, 1'b1);
        chk("s4_cpu_rdata", cpu_rdata, 8'h0F);
      end
    end

    // S5: reset the cycle after a display grant discards the read
    @(negedge clk);
    disp_addr = 12'h010;
    #1;
    chk("s5_disp_gnt", disp_gnt, 1'b1);
    @(negedge clk);
    reset = 1'b1; disp_req = 1'b0;
    #1;
    chk("s5_disp_valid", disp_valid, 1'b0);
    chk("s5_gnts", {disp_gnt, cpu_gnt, cpu_rvalid, mem_we}, 4'b0000);
    chk("s5_mem_addr", mem_addr, 12'h000);
    chk("s5_rdata", {disp_rdata, cpu_rdata}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("s5_state", 32'(dut.state_r), 32'(CPU_PRI));
    chk("s5_valid_after", {disp_valid, cpu_rvalid}, 2'b00);

    // S6: random traffic with holding requesters and a read-data scoreboard
    cwait = 0; dwait = 0; max_c = 0; max_d = 0; both_cnt = 0; rd_err = 0;
    d_g = 1'b0; c_g = 1'b0; exp_dv = 1'b0; exp_cv = 1'b0;
    exp_dd = 8'h00; exp_cd = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (disp_valid !== exp_dv || (exp_dv && disp_rdata !== exp_dd)) rd_err++;
      if (cpu_rvalid !== exp_cv || (exp_cv && cpu_rdata !== exp_cd)) rd_err++;
      if ($urandom_range(0, 99) < 3) blank = ~blank;
      if (!disp_req || d_g) begin
        disp_req  = ($urandom_range(0, 99) < 70);
        disp_addr = 12'($urandom_range(0, 4095));
      end
      if (!cpu_req || c_g) begin
        cpu_req   = ($urandom_range(0, 99) < 70);
        cpu_we    = ($urandom_range(0, 99) < 30);
        cpu_addr  = 12'($urandom_range(0, 4095));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
      #1;
      d_g = disp_gnt; c_g = cpu_gnt;
      if (d_g && c_g) both_cnt++;
      exp_dv = d_g;
      exp_dd = rd_exp(disp_addr);
      exp_cv = c_g && !cpu_we;
      exp_cd = rd_exp(cpu_addr);
      if (c_g && cpu_we) begin
        ref_mem[cpu_addr] = cpu_wdata;
        ref_wr[cpu_addr]  = 1'b1;
      end
      if (cpu_req && !blank) begin
        if (c_g) begin
          if (cwait + 1 > max_c) max_c = cwait + 1;
          cwait = 0;
        end else begin
          cwait++;
        end
      end else begin
        cwait = 0;
      end
      if (disp_req && !blank) begin
        if (d_g) begin
          if (dwait + 1 > max_d) max_d = dwait + 1;
          dwait = 0;
        end else begin
          dwait++;
        end
      end else begin
        dwait = 0;
      end
    end
    chk("rnd_both_gnt", both_cnt, 0);
    chk("rnd_rdata_err", rd_err, 0);
    chk("rnd_cpu_wait_ok", (max_c <= MW + 1), 1'b1);
    chk("rnd_disp_wait_ok", (max_d <= MW + 1), 1'b1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
